fetch_lookahead_stage: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register. It feeds the decode-stage control unit with the current opcode and the lookahead next_opcode. Each cycle it reads two consecutive instruction words (pc, pc+1). A jump in the pc+1 slot is folded at zero penalty: the jump never issues, and PC is redirected in the same cycle. A jump in the head slot costs one bubble.

---
 rtl/fetch_lookahead_stage_pkg.sv | 19 +
 rtl/fetch_next_pc.sv | 48 ++++
 rtl/fetch_lookahead_stage.sv | 120 ++++++++++++
 tb/tb_fetch_lookahead_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_lookahead_stage_pkg.sv
// Shared definitions for the fetch/lookahead stage and the decode control unit.
package fetch_lookahead_stage_pkg;

    localparam logic [1:0] OP_MOV  = 2'b00;
    localparam logic [1:0] OP_ADDI = 2'b01;
    localparam logic [1:0] OP_NOP  = 2'b10;
    localparam logic [1:0] OP_JMP  = 2'b11;

    // Opcode occupies the top OP_W bits of a word; jump target starts at TGT_LSB.
    localparam int OP_W    = 2;
    localparam int TGT_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection for the two-word fetch window.
// A jump in the head slot does not issue; a jump in the lookahead slot is folded.
module fetch_next_pc
    import fetch_lookahead_stage_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int INSTR_W = 8
) (
    input  logic [ADDR_W-1:0]  pc,
    input  logic [INSTR_W-1:0] i0,
    input  logic [INSTR_W-1:0] i1,
    output logic [ADDR_W-1:0]  next_pc,
    output logic               issue,
    output logic               fold,
    output logic               halt_req
);

    logic [OP_W-1:0]   op0;
    logic [OP_W-1:0]   op1;
    logic [ADDR_W-1:0] tgt0;
    logic [ADDR_W-1:0] tgt1;

    assign op0  = i0[INSTR_W-1 -: OP_W];
    assign op1  = i1[INSTR_W-1 -: OP_W];
    assign tgt0 = i0[TGT_LSB +: ADDR_W];
    assign tgt1 = i1[TGT_LSB +: ADDR_W];

    // Classify the window: head jump, folded jump, or sequential.
    always_comb begin
        next_pc  = pc + ADDR_W'(1);
        issue    = 1'b1;
        fold     = 1'b0;
        halt_req = 1'b0;
        if (op0 == OP_JMP) begin
            issue = 1'b0;
            if (tgt0 == pc) begin
                halt_req = 1'b1;
                next_pc  = pc;
            end else begin
                next_pc = tgt0;
            end
        end else if (op1 == OP_JMP) begin
            fold    = 1'b1;
            next_pc = tgt1;
        end
    end

endmodule

// File: rtl/fetch_lookahead_stage.sv
// Instruction fetch with zero-penalty jump folding and the IF/ID register.
// state   | meaning
// IDLE    | waiting for en, IF/ID holds a bubble
// RUN     | fetching and issuing one instruction per cycle
// HALT    | self-loop jump seen, absorbing until reset
module fetch_lookahead_stage
    import fetch_lookahead_stage_pkg::*;
#(
    parameter int              ADDR_W   = 6,
    parameter int              INSTR_W  = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               stall,
    output logic [ADDR_W-1:0]  imem_addr0,
    input  logic [INSTR_W-1:0] imem_data0,
    output logic [ADDR_W-1:0]  imem_addr1,
    input  logic [INSTR_W-1:0] imem_data1,
    output logic [INSTR_W-1:0] id_instr,
    output logic [1:0]         id_opcode,
    output logic [1:0]         id_next_opcode,
    output logic [ADDR_W-1:0]  id_pc,
    output logic               id_valid,
    output logic               halted,
    output logic [15:0]        fold_count
);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_d;
    logic [ADDR_W-1:0]  idpc_d;
    logic [1:0]         op_d, nop_d;
    logic               valid_d;
    logic [15:0]        fold_d;

    logic [ADDR_W-1:0]  next_pc;
    logic               issue, fold, halt_req;

    assign imem_addr0 = pc_q;
    assign imem_addr1 = pc_q + ADDR_W'(1);
    assign halted     = (state_q == ST_HALT);

    fetch_next_pc #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_next_pc (
        .pc       (pc_q),
        .i0       (imem_data0),
        .i1       (imem_data1),
        .next_pc  (next_pc),
        .issue    (issue),
        .fold     (fold),
        .halt_req (halt_req)
    );

    // Next-state and IF/ID load decisions; stall freezes everything.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = id_instr;
        idpc_d  = id_pc;
        op_d    = id_opcode;
        nop_d   = id_next_opcode;
        valid_d = id_valid;
        fold_d  = fold_count;
        if (!stall) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (en) state_d = ST_RUN;
                end
                ST_RUN: begin
                    pc_d = next_pc;
                    if (!issue) begin
                        // Bubble must look like a nop to the control unit.
                        valid_d = 1'b0;
                        op_d    = OP_NOP;
                        nop_d   = OP_NOP;
                        if (halt_req) state_d = ST_HALT;
                    end else begin
                        instr_d = imem_data0;
                        idpc_d  = pc_q;
                        op_d    = imem_data0[INSTR_W-1 -: OP_W];
                        nop_d   = fold ? OP_JMP : imem_data1[INSTR_W-1 -: OP_W];
                        valid_d = 1'b1;
                        if (fold && (fold_count != 16'hFFFF)) fold_d = fold_count + 16'd1;
                    end
                end
                ST_HALT: begin
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, PC, IF/ID register and fold counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            pc_q           <= RESET_PC;
            id_instr       <= '0;
            id_pc          <= '0;
            id_opcode      <= OP_NOP;
            id_next_opcode <= OP_NOP;
            id_valid       <= 1'b0;
            fold_count     <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            id_instr       <= instr_d;
            id_pc          <= idpc_d;
            id_opcode      <= op_d;
            id_next_opcode <= nop_d;
            id_valid       <= valid_d;
            fold_count     <= fold_d;
        end
    end

endmodule

// File: tb/tb_fetch_lookahead_stage.sv
// Bench for fetch_lookahead_stage: directed scenarios plus random programs
// compared against a behavioural model of the fetch rules.
module tb_fetch_lookahead_stage;

    logic        clk = 1'b0;
    logic        reset, en, stall;
    logic [5:0]  imem_addr0, imem_addr1, id_pc;
    logic [7:0]  imem_data0, imem_data1, id_instr;
    logic [1:0]  id_opcode, id_next_opcode;
    logic        id_valid, halted;
    logic [15:0] fold_count;

    logic [7:0]  mem [64];

    int n_vec = 0;
    int n_err = 0;

    // Model state
    int m_pc, m_instr, m_idpc, m_op, m_nop, m_fold;
    bit m_run, m_halt, m_valid;

    always #5 clk = ~clk;

    assign imem_data0 = mem[imem_addr0];
    assign imem_data1 = mem[imem_addr1];

    fetch_lookahead_stage dut (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .stall          (stall),
        .imem_addr0     (imem_addr0),
        .imem_data0     (imem_data0),
        .imem_addr1     (imem_addr1),
        .imem_data1     (imem_data1),
        .id_instr       (id_instr),
        .id_opcode      (id_opcode),
        .id_next_opcode (id_next_opcode),
        .id_pc          (id_pc),
        .id_valid       (id_valid),
        .halted         (halted),
        .fold_count     (fold_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_instr = 0; m_idpc = 0; m_op = 2; m_nop = 2;
        m_fold = 0; m_run = 0; m_halt = 0; m_valid = 0;
    endtask

    // One rising edge of the fetch rules, written directly from the opcode semantics.
    task automatic model_edge(input bit e, input bit s);
        int w0, w1;
        if (s || m_halt) return;
        if (!m_run) begin
            if (e) m_run = 1;
            return;
        end
        w0 = mem[m_pc];
        w1 = mem[(m_pc + 1) % 64];
        if (w0 / 64 == 3) begin
            m_valid = 0; m_op = 2; m_nop = 2;
            if (w0 % 64 == m_pc) begin
                m_halt = 1; m_run = 0;
            end else begin
                m_pc = w0 % 64;
            end
        end else begin
            m_instr = w0; m_idpc = m_pc; m_op = w0 / 64; m_valid = 1;
            if (w1 / 64 == 3) begin
                m_nop = 3;
                m_pc = w1 % 64;
                if (m_fold < 65535) m_fold++;
            end else begin
                m_nop = w1 / 64;
                m_pc = (m_pc + 1) % 64;
            end
        end
    endtask

    task automatic compare_all();
        chk("addr0", imem_addr0, m_pc);
        chk("addr1", imem_addr1, (m_pc + 1) % 64);
        chk("valid", id_valid, m_valid);
        chk("opcode", id_opcode, m_op);
        chk("next_opcode", id_next_opcode, m_nop);
        chk("halted", halted, m_halt);
        chk("fold_count", fold_count, m_fold);
        if (m_valid) begin
            chk("id_instr", id_instr, m_instr);
            chk("id_pc", id_pc, m_idpc);
        end
    endtask

    task automatic step(input bit e, input bit s);
        @(negedge clk);
        en = e; stall = s;
        model_edge(e, s);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Reset asserted away from the clock edge; outputs must clear before the next edge.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; en = 1'b0; stall = 1'b0;
        model_reset();
        #1;
        compare_all();
        chk("reset_instr", id_instr, 0);
        chk("reset_idpc", id_pc, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic fill(input logic [7:0] w);
        for (int i = 0; i < 64; i++) mem[i] = w;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; stall = 1'b0;
        fill(8'h00);
        model_reset();
        #12;
        compare_all();

        // Sequential issue, then stall across a fold, then fold completion.
        mem[0] = 8'b00_000001; mem[1] = 8'b01_000010; mem[2] = 8'b10_000000;
        mem[4] = 8'b01_010101; mem[5] = 8'b11_010100;
        do_reset();
        step(1, 1);
        chk("idle_stall_halt", halted, 0);
        step(1, 0);
        chk("first_bubble", id_valid, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0);
            chk("seq_pc", id_pc, k);
        end
        step(0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 1);
            chk("stall_pc", id_pc, 3);
            chk("stall_addr", imem_addr0, 4);
        end
        step(0, 0);
        chk("fold_pc", id_pc, 4);
        chk("fold_nop", id_next_opcode, 2'b11);
        chk("fold_cnt", fold_count, 1);
        step(0, 0);
        chk("fold_tgt", id_pc, 20);
        chk("fold_novalidgap", id_valid, 1);

        // Head jump, then fold onto a self loop, then HALT.
        fill(8'h00);
        mem[0] = 8'b11_001000; mem[9] = 8'b11_001001;
        do_reset();
        step(1, 0);
        step(0, 0);
        chk("head_bubble", id_valid, 0);
        chk("head_op", id_opcode, 2'b10);
        step(0, 0);
        chk("head_tgt", id_pc, 8);
        step(0, 0);
        chk("halt", halted, 1);
        for (int k = 0; k < 4; k++) begin
            step(k[0], 0);
            chk("halt_addr", imem_addr0, 9);
        end

        // Wrap through address 63 with no jumps, then reset mid-run.
        fill(8'h40);
        do_reset();
        step(1, 0);
        for (int k = 0; k < 70; k++) step(0, 0);
        do_reset();
        chk("mid_reset_valid", id_valid, 0);

        // Random programs with random stall and en.
        for (int seg = 0; seg < 20; seg++) begin
            for (int i = 0; i < 64; i++) begin
                logic [1:0] op;
                op = ($urandom_range(0, 5) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                mem[i] = {op, 6'($urandom_range(0, 63))};
            end
            do_reset();
            for (int k = 0; k < 150; k++)
                step(1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
